// File: rtl/alu_muldiv_nbit_if.sv
// Request/result bundle for the multi-cycle ALU with shift-add multiply and restoring divide.
interface alu_muldiv_nbit_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] result_lo;
  logic [N-1:0] result_hi;
  logic         busy;
  logic         done;
  logic         zero_flag;
  logic         sign_flag;
  logic         carry_flag;
  logic         dz_flag;

  modport master (
    output start, op, a, b,
    input  result_lo, result_hi, busy, done, zero_flag, sign_flag, carry_flag, dz_flag
  );

  modport slave (
    input  start, op, a, b,
    output result_lo, result_hi, busy, done, zero_flag, sign_flag, carry_flag, dz_flag
  );
endinterface

// File: rtl/alu_muldiv_nbit.sv
// N-bit ALU: single-cycle add/sub/logic, N-cycle unsigned shift-add multiply and restoring divide.
module alu_muldiv_nbit #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             reset_p,
  alu_muldiv_nbit_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [2:0]    op_q;
  logic [N-1:0]  a_q, b_q;
  logic [N:0]    w_hi;
  logic [N-1:0]  w_lo;
  logic [CW-1:0] cnt;

  logic [N-1:0] res_lo_q, res_hi_q;
  logic         zero_q, sign_q, carry_q, dz_q, busy_q, done_q;

  logic [N:0]   w_hi_nx;
  logic [N-1:0] w_lo_nx;
  logic [N:0]   mul_sum;
  logic [2*N:0] mul_sh;
  logic [N:0]   div_sh, div_trial;
  logic         div_ge;

  logic         load;
  logic [N:0]   add_sum;
  logic [N-1:0] lo_nx, hi_nx;
  logic         z_nx, s_nx, c_nx, d_nx;

  // One iteration of the multiply (w_hi:w_lo = partial product) or divide (w_hi = rem, w_lo = quotient/dividend).
  always_comb begin
    mul_sum   = w_hi + (w_lo[0] ? {1'b0, a_q} : '0);
    mul_sh    = {mul_sum, w_lo} >> 1;
    div_sh    = {w_hi[N-1:0], w_lo[N-1]};
    div_ge    = (div_sh >= {1'b0, b_q});
    div_trial = div_sh - {1'b0, b_q};
    if (op_q == OP_MUL) begin
      w_hi_nx = mul_sh[2*N:N];
      w_lo_nx = mul_sh[N-1:0];
    end else begin
      w_hi_nx = div_ge ? div_trial : div_sh;
      w_lo_nx = {w_lo[N-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE);
      done_q <= (state_nx == DONE);
    end
  end

  // Next state plus the result/flag values written on the edge that enters DONE.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    lo_nx    = '0;
    hi_nx    = '0;
    z_nx     = 1'b0;
    s_nx     = 1'b0;
    c_nx     = 1'b0;
    d_nx     = 1'b0;
    add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0)) begin
            state_nx = CALC;
          end else begin
            state_nx = DONE;
            load     = 1'b1;
            case (bus.op)
              OP_ADD: begin
                lo_nx = add_sum[N-1:0];
                c_nx  = add_sum[N];
                z_nx  = (add_sum[N-1:0] == '0);
              end
              OP_SUB: begin
                lo_nx = bus.a - bus.b;
                s_nx  = (bus.a < bus.b);
                z_nx  = (bus.a == bus.b);
              end
              OP_AND: begin
                lo_nx = bus.a & bus.b;
                z_nx  = ((bus.a & bus.b) == '0);
              end
              OP_OR: begin
                lo_nx = bus.a | bus.b;
                z_nx  = ((bus.a | bus.b) == '0);
              end
              OP_XOR: begin
                lo_nx = bus.a ^ bus.b;
                z_nx  = ((bus.a ^ bus.b) == '0);
              end
              OP_DIV: begin
                lo_nx = '1;
                hi_nx = bus.a;
                d_nx  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      CALC: begin
        if (cnt == CW'(N - 1)) begin
          state_nx = DONE;
          load     = 1'b1;
          lo_nx    = w_lo_nx;
          hi_nx    = w_hi_nx[N-1:0];
          if (op_q == OP_MUL) z_nx = ({w_hi_nx[N-1:0], w_lo_nx} == '0);
          else                z_nx = (w_lo_nx == '0);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, iteration registers and result/flag registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      w_hi     <= '0;
      w_lo     <= '0;
      cnt      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
        w_hi <= '0;
        w_lo <= (bus.op == OP_MUL) ? bus.b : bus.a;
        cnt  <= '0;
      end else if (state == CALC) begin
        w_hi <= w_hi_nx;
        w_lo <= w_lo_nx;
        cnt  <= cnt + CW'(1);
      end
      if (load) begin
        res_lo_q <= lo_nx;
        res_hi_q <= hi_nx;
        zero_q   <= z_nx;
        sign_q   <= s_nx;
        carry_q  <= c_nx;
        dz_q     <= d_nx;
      end
    end
  end

  assign bus.result_lo  = res_lo_q;
  assign bus.result_hi  = res_hi_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.zero_flag  = zero_q;
  assign bus.sign_flag  = sign_q;
  assign bus.carry_flag = carry_q;
  assign bus.dz_flag    = dz_q;
endmodule

// File: tb/tb_alu_muldiv_nbit.sv
// Self-checking bench: cycle-level arithmetic reference model, per-cycle compare and directed literal checks.
module tb_alu_muldiv_nbit;
  localparam int unsigned N = 8;

  typedef struct packed {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         z;
    logic         s;
    logic         c;
    logic         d;
  } res_t;

  logic clk = 1'b0;
  logic reset_p = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_nbit_if #(.N(N)) bus ();
  alu_muldiv_nbit #(.N(N)) dut (.clk(clk), .reset_p(reset_p), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Expected outputs, derived from plain arithmetic on the accepted operands.
  res_t e_res = '0;
  res_t p_res = '0;
  logic e_busy = 1'b0;
  logic e_done = 1'b0;
  int   rem = 0;

  function automatic res_t compute(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    res_t r;
    longint ai, bi, m, t;
    r  = '0;
    ai = longint'(a);
    bi = longint'(b);
    m  = longint'(1) << N;
    case (op)
      3'd0: begin t = ai + bi; r.lo = N'(t % m); r.c = (t >= m); r.z = (t % m == 0); end
      3'd1: begin t = (ai - bi + m) % m; r.lo = N'(t); r.s = (ai < bi); r.z = (t == 0); end
      3'd2: begin r.lo = a & b; r.z = (r.lo == 0); end
      3'd3: begin r.lo = a | b; r.z = (r.lo == 0); end
      3'd4: begin r.lo = a ^ b; r.z = (r.lo == 0); end
      3'd5: begin t = ai * bi; r.lo = N'(t % m); r.hi = N'(t / m); r.z = (t == 0); end
      3'd6: begin
        if (bi == 0) begin r.lo = N'(m - 1); r.hi = a; r.d = 1'b1; end
        else begin r.lo = N'(ai / bi); r.hi = N'(ai % bi); r.z = (ai / bi == 0); end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [N-1:0] b);
    return (op == 3'd5 || (op == 3'd6 && b != 0)) ? int'(N) + 1 : 1;
  endfunction

  // Model timeline: rem counts edges left until the result lands.
  always @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      rem    <= 0;
      e_done <= 1'b0;
      e_busy <= 1'b0;
      e_res  <= '0;
    end else if (e_done) begin
      e_done <= 1'b0;
      e_busy <= 1'b0;
    end else if (rem > 1) begin
      rem <= rem - 1;
    end else if (rem == 1) begin
      rem    <= 0;
      e_done <= 1'b1;
      e_res  <= p_res;
    end else if (bus.start) begin
      e_busy <= 1'b1;
      if (latency(bus.op, bus.b) == 1) begin
        e_done <= 1'b1;
        e_res  <= compute(bus.op, bus.a, bus.b);
      end else begin
        rem   <= latency(bus.op, bus.b) - 1;
        p_res <= compute(bus.op, bus.a, bus.b);
      end
    end
  end

  task automatic cycle_check();
    logic [2*N+5:0] got, exp;
    got = {bus.busy, bus.done, bus.result_hi, bus.result_lo,
           bus.zero_flag, bus.sign_flag, bus.carry_flag, bus.dz_flag};
    exp = {e_busy, e_done, e_res};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL cycle t=%0t busy/done/hi/lo/zscd got=%h expected=%h", $time, got, exp);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // mode 0: quiet inputs; 1: ignored ADD request at cycle 3; 2: inputs scrambled every cycle.
  task automatic run_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int mode, output int cyc, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc  = 1;
    bcnt = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) bcnt++;
      if (mode == 1 && cyc == 3) begin
        bus.start = 1'b1; bus.op = 3'd0; bus.a = N'(3); bus.b = N'(4);
      end else if (mode == 2) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op    = 3'($urandom);
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) bcnt++;
    bus.start = 1'b0;
  endtask

  initial begin
    int cyc, bc;
    logic [2:0] rop;
    logic [N-1:0] ra, rb;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    #1 reset_p = 1'b1;
    fork
      forever begin
        @(negedge clk);
        cycle_check();
      end
    join_none
    repeat (2) @(negedge clk);
    check_lit("reset_lo", 32'(bus.result_lo), 0);
    check_lit("reset_busy_done", 32'({bus.busy, bus.done}), 0);
    reset_p = 1'b0;

    run_op(3'd0, 8'd200, 8'd100, 0, cyc, bc);
    check_lit("add_lat", cyc, 1);
    check_lit("add_lo", 32'(bus.result_lo), 44);
    check_lit("add_hi", 32'(bus.result_hi), 0);
    check_lit("add_cz", 32'({bus.carry_flag, bus.zero_flag}), 2);

    run_op(3'd1, 8'd5, 8'd9, 0, cyc, bc);
    check_lit("sub_lo", 32'(bus.result_lo), 252);
    check_lit("sub_sc", 32'({bus.sign_flag, bus.carry_flag}), 2);
    run_op(3'd1, 8'd7, 8'd7, 0, cyc, bc);
    check_lit("sub0_lo", 32'(bus.result_lo), 0);
    check_lit("sub0_zs", 32'({bus.zero_flag, bus.sign_flag}), 2);

    run_op(3'd5, 8'd255, 8'd255, 1, cyc, bc);
    check_lit("mul_lat", cyc, 9);
    check_lit("mul_busy_cycles", bc, 9);
    check_lit("mul_hi", 32'(bus.result_hi), 32'hFE);
    check_lit("mul_lo", 32'(bus.result_lo), 32'h01);

    run_op(3'd6, 8'd200, 8'd7, 0, cyc, bc);
    check_lit("div_lat", cyc, 9);
    check_lit("div_q", 32'(bus.result_lo), 28);
    check_lit("div_r", 32'(bus.result_hi), 4);
    check_lit("div_dz", 32'(bus.dz_flag), 0);

    run_op(3'd6, 8'd200, 8'd0, 0, cyc, bc);
    check_lit("divz_lat", cyc, 1);
    check_lit("divz_lo", 32'(bus.result_lo), 255);
    check_lit("divz_hi", 32'(bus.result_hi), 200);
    check_lit("divz_dz", 32'(bus.dz_flag), 1);

    // Reset four cycles into a multiply, after a prior ADD result.
    run_op(3'd0, 8'd10, 8'd20, 0, cyc, bc);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 8'd3; bus.b = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_p = 1'b1;
    #1;
    check_lit("rst_async_outs", 32'({bus.result_hi, bus.result_lo, bus.busy, bus.done,
              bus.zero_flag, bus.sign_flag, bus.carry_flag, bus.dz_flag}), 0);
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    run_op(3'd0, 8'd1, 8'd1, 0, cyc, bc);
    check_lit("post_rst_add", 32'(bus.result_lo), 2);

    run_op(3'd6, 8'd100, 8'd10, 2, cyc, bc);
    check_lit("div_scr_q", 32'(bus.result_lo), 10);
    check_lit("div_scr_r", 32'(bus.result_hi), 0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = N'($urandom);
      rb  = N'($urandom);
      if (rop == 3'd6 && $urandom_range(0, 3) == 0) rb = '0;
      run_op(rop, ra, rb, int'($urandom_range(0, 2)), cyc, bc);
      check_lit("rand_lat", cyc, latency(rop, rb));
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_nbit.md
ALU_MULDIV_NBIT -- requirements
Module: alu_muldiv_nbit

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand/result width in bits (N >= 4).
REQ-002 The block SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 The block SHALL have port reset_p  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  input  1  operation request; sampled only in IDLE.
REQ-005 The block SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV, 111 reserved.
REQ-006 The block SHALL have port a  input  N  first operand (dividend for DIV).
REQ-007 The block SHALL have port b  input  N  second operand (divisor for DIV).
REQ-008 The block SHALL have port result_lo  output  N  result, or low product half, or quotient.
REQ-009 The block SHALL have port result_hi  output  N  high product half, or remainder; 0 for ADD/SUB/logic ops.
REQ-010 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have ports zero_flag, sign_flag, carry_flag, dz_flag  output  1 each  registered status flags.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-014 In IDLE with start=1, op, a and b SHALL be latched at that edge; later input changes are ignored until IDLE is re-entered.
REQ-015 ADD, SUB, AND, OR, XOR, reserved opcodes and DIV with b=0 SHALL go IDLE->DONE, so done is high in the cycle after the accepting edge (latency 1).
REQ-016 MUL and DIV with b!=0 SHALL go IDLE->CALC, stay in CALC for exactly N cycles (one bit per cycle), then enter DONE (done high N+1 cycles after the accepting edge).
REQ-017 DONE SHALL always return to IDLE on the next edge; start is ignored while busy, including during DONE.
REQ-018 ADD SHALL give result_lo = (a+b) mod 2^N, carry_flag = carry out of bit N-1.
REQ-019 SUB SHALL give result_lo = (a-b) mod 2^N; sign_flag = 1 when a < b (unsigned); carry_flag = 0.
REQ-020 AND/OR/XOR SHALL give the bitwise result in result_lo.
REQ-021 MUL SHALL be unsigned shift-add: {result_hi, result_lo} = a*b (2N bits).
REQ-022 DIV SHALL be unsigned restoring division: result_lo = a/b, result_hi = a mod b.
REQ-023 DIV with b=0 SHALL give result_lo = all ones, result_hi = a, dz_flag = 1.
REQ-024 Reserved opcode 111 SHALL give result_lo = result_hi = 0 with all flags 0.
REQ-025 zero_flag SHALL be 1 when result_lo is 0 for ADD/SUB/logic/DIV, and when {result_hi, result_lo} is 0 for MUL.
REQ-026 A flag not defined for the completing opcode SHALL be written 0.
REQ-027 result_lo, result_hi and all flags SHALL update only on the edge entering DONE, and SHALL hold until the next completion.
REQ-028 CALC-phase intermediate values SHALL NOT appear on result_lo/result_hi.

Reset
REQ-029 reset_p=1 SHALL immediately, without a clock, force state to IDLE and drive result_lo, result_hi, busy, done and all four flags to 0.
REQ-030 Reset asserted during CALC or DONE SHALL abort the operation, with no done pulse and no result update.
REQ-031 After reset deasserts, the first start in IDLE SHALL be accepted normally.

Verification (N=8)
REQ-032 ADD a=200, b=100 -> result_lo=44, result_hi=0, carry_flag=1, zero_flag=0; done 1 cycle after accept.
REQ-033 SUB a=5, b=9 -> result_lo=252, sign_flag=1, carry_flag=0; then SUB 7-7 -> result_lo=0, zero_flag=1, sign_flag=0.
REQ-034 MUL a=255, b=255 -> result_hi=0xFE, result_lo=0x01, done exactly 9 cycles after accept, busy high for 9 cycles; start pulsed at cycle 3 with other operands is ignored.
REQ-035 DIV a=200, b=7 -> result_lo=28, result_hi=4, dz_flag=0 after 9 cycles; DIV a=200, b=0 -> result_lo=255, result_hi=200, dz_flag=1, done after 1 cycle.
REQ-036 reset_p pulsed 4 cycles into a MUL after a prior ADD result -> all outputs 0 immediately, no done; next ADD 1+1 -> result_lo=2.
REQ-037 Operands changed every cycle during a DIV 100/10 -> result_lo=10, result_hi=0 (latched operands used).
